// File: rtl/ext_bus_arbiter_if.sv
// Channel-side and system-bus-side signals of the external databus arbiter.
// slave is the arbiter's view; master is the surrounding environment's view.
interface ext_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*STRB_W-1:0] req_wstrb;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       req_rdata;

    logic                    m_valid;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [STRB_W-1:0]       m_wstrb;
    logic                    m_ready;
    logic [DATA_W-1:0]       m_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        output req_ready, req_rdata,
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb,
        input  req_ready, req_rdata,
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter sharing one external databus between N_REQ address-generator
// channels; a granted channel keeps the bus while it holds valid, up to max_burst beats.
module ext_bus_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BURST_W-1:0] max_burst,
    ext_bus_arbiter_if.slave   bus,
    output logic [N_REQ-1:0]   grant,
    output logic               busy
);
    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BURST_W-1:0] burst_lim_q, burst_lim_d;

    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;
    logic               sel_valid;
    logic               beat;
    logic               burst_done;

    // First requesting channel scanning upward from rr_q with wrap at N_REQ-1
    always_comb begin : arb_scan
        int unsigned idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!pick_vld && bus.req_valid[PTR_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(idx);
            end
        end
    end

    assign sel_valid  = (state_q == GRANT) && bus.req_valid[sel_q];
    assign beat       = sel_valid && bus.m_ready;
    // Widened compare so a limit of all-ones is still reachable
    assign burst_done = beat && (burst_lim_q != '0) &&
                        (({1'b0, beat_cnt_q} + (BURST_W+1)'(1)) == {1'b0, burst_lim_q});

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_lim_d = burst_lim_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = GRANT;
                    grant_d     = N_REQ'(1) << pick_idx;
                    sel_d       = pick_idx;
                    burst_lim_d = max_burst;
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (beat && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + BURST_W'(1);
                if (!sel_valid || burst_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = (sel_q == LAST_IDX) ? '0 : sel_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            rr_q        <= '0;
            beat_cnt_q  <= '0;
            burst_lim_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_lim_q <= burst_lim_d;
        end
    end

    // Bus <-> granted channel forwarding; everything idles to zero outside GRANT
    always_comb begin
        bus.m_valid   = 1'b0;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;
        bus.req_ready = '0;
        if (state_q == GRANT) begin
            bus.m_valid          = bus.req_valid[sel_q];
            bus.req_ready[sel_q] = bus.m_ready;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (sel_q == PTR_W'(i)) begin
                    bus.m_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                    bus.m_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                    bus.m_wstrb = bus.req_wstrb[i*STRB_W +: STRB_W];
                end
            end
        end
    end

    assign bus.req_rdata = bus.m_rdata;
    assign grant         = grant_q;
    assign busy          = (state_q == GRANT);

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: a 4-channel and a 3-channel instance.
module tb_ext_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] max_burst4, max_burst3;
    logic [3:0] grant4;
    logic [2:0] grant3;
    logic       busy4, busy3;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    ext_bus_arbiter_if #(.N_REQ(4), .DATA_W(32), .ADDR_W(32)) b4 ();
    ext_bus_arbiter_if #(.N_REQ(3), .DATA_W(32), .ADDR_W(32)) b3 ();

    ext_bus_arbiter #(.N_REQ(4), .DATA_W(32), .ADDR_W(32), .BURST_W(8)) dut4 (
        .clk(clk), .rst(rst), .max_burst(max_burst4), .bus(b4), .grant(grant4), .busy(busy4));
    ext_bus_arbiter #(.N_REQ(3), .DATA_W(32), .ADDR_W(32), .BURST_W(8)) dut3 (
        .clk(clk), .rst(rst), .max_burst(max_burst3), .bus(b3), .grant(grant3), .busy(busy3));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b4.req_valid = '0; b4.req_addr = '0; b4.req_wdata = '0; b4.req_wstrb = '0;
        b4.m_ready = 1'b0; b4.m_rdata = '0;
        b3.req_valid = '0; b3.req_addr = '0; b3.req_wdata = '0; b3.req_wstrb = '0;
        b3.m_ready = 1'b0; b3.m_rdata = '0;
        max_burst4 = '0; max_burst3 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [3:0]  exp_g [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                                4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    logic [31:0] exp_addr;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        // Reset state
        check_eq("rst_grant", 64'(grant4), 64'h0);
        check_eq("rst_busy", 64'(busy4), 64'h0);
        check_eq("rst_m_valid", 64'(b4.m_valid), 64'h0);
        check_eq("rst_m_addr", 64'(b4.m_addr), 64'h0);
        check_eq("rst_req_ready", 64'(b4.req_ready), 64'h0);
        check_eq("rst_rr", 64'(dut4.rr_q), 64'h0);
        b4.m_rdata = 32'hDEADBEEF;
        #1 check_eq("rdata_passthru", 64'(b4.req_rdata), 64'hDEADBEEF);
        rst = 1'b0;

        // Single requester ch2, three beats, then valid drops
        b4.req_addr[2*32 +: 32] = 32'h100;
        b4.req_valid = 4'b0100;
        b4.m_ready = 1'b1;
        #1 check_eq("s1_idle_grant", 64'(grant4), 64'h0);
        step();
        check_eq("s1_grant", 64'(grant4), 64'h4);
        check_eq("s1_busy", 64'(busy4), 64'h1);
        check_eq("s1_m_valid", 64'(b4.m_valid), 64'h1);
        check_eq("s1_m_addr", 64'(b4.m_addr), 64'h100);
        check_eq("s1_req_ready", 64'(b4.req_ready), 64'h4);
        step();
        check_eq("s1_beat1", 64'(dut4.beat_cnt_q), 64'h1);
        step();
        check_eq("s1_beat2", 64'(dut4.beat_cnt_q), 64'h2);
        step();
        b4.req_valid = 4'b0000;
        #1 check_eq("s1_beat3", 64'(dut4.beat_cnt_q), 64'h3);
        check_eq("s1_drop_m_valid", 64'(b4.m_valid), 64'h0);
        check_eq("s1_drop_grant", 64'(grant4), 64'h4);
        step();
        check_eq("s1_rel_grant", 64'(grant4), 64'h0);
        check_eq("s1_rel_busy", 64'(busy4), 64'h0);
        check_eq("s1_rr", 64'(dut4.rr_q), 64'h3);

        // All four channels, max_burst=2: two beats each, one idle cycle between grants
        idle_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) b4.req_addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
        b4.req_valid = 4'b1111;
        b4.m_ready = 1'b1;
        max_burst4 = 8'd2;
        for (int c = 0; c < 15; c++) begin
            #1;
            exp_addr = 32'h0;
            for (int j = 0; j < 4; j++)
                if (exp_g[c][j]) exp_addr = 32'h1000 + 32'(j * 16);
            check_eq($sformatf("s2_grant_c%0d", c), 64'(grant4), 64'(exp_g[c]));
            check_eq($sformatf("s2_m_valid_c%0d", c), 64'(b4.m_valid), 64'(exp_g[c] != 4'h0));
            check_eq($sformatf("s2_m_addr_c%0d", c), 64'(b4.m_addr), 64'(exp_addr));
            step();
        end

        // Backpressure on ch1: grant held, address stable, ready low
        idle_inputs();
        do_reset();
        b4.req_addr[1*32 +: 32]  = 32'h2000;
        b4.req_wdata[1*32 +: 32] = 32'hCAFE0001;
        b4.req_wstrb[1*4 +: 4]   = 4'hF;
        b4.req_valid = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("s3_grant_c%0d", c), 64'(grant4), 64'h2);
            check_eq($sformatf("s3_m_valid_c%0d", c), 64'(b4.m_valid), 64'h1);
            check_eq($sformatf("s3_ready_c%0d", c), 64'(b4.req_ready), 64'h0);
            check_eq($sformatf("s3_m_addr_c%0d", c), 64'(b4.m_addr), 64'h2000);
            check_eq($sformatf("s3_cnt_c%0d", c), 64'(dut4.beat_cnt_q), 64'h0);
            step();
        end
        b4.m_ready = 1'b1;
        #1 check_eq("s3_ready_go", 64'(b4.req_ready), 64'h2);
        check_eq("s3_m_wdata", 64'(b4.m_wdata), 64'hCAFE0001);
        check_eq("s3_m_wstrb", 64'(b4.m_wstrb), 64'hF);
        step();
        b4.req_valid = 4'b0000;
        b4.m_ready = 1'b0;
        #1 check_eq("s3_cnt_after", 64'(dut4.beat_cnt_q), 64'h1);
        check_eq("s3_grant_after", 64'(grant4), 64'h2);
        step();
        check_eq("s3_rel_grant", 64'(grant4), 64'h0);
        check_eq("s3_rr", 64'(dut4.rr_q), 64'h2);

        // Zero-beat release: ch0 valid for a single cycle
        idle_inputs();
        do_reset();
        b4.m_ready = 1'b1;
        b4.req_valid = 4'b0001;
        step();
        b4.req_valid = 4'b0000;
        #1 check_eq("s4_grant", 64'(grant4), 64'h1);
        check_eq("s4_m_valid", 64'(b4.m_valid), 64'h0);
        step();
        check_eq("s4_rel_grant", 64'(grant4), 64'h0);
        check_eq("s4_rr", 64'(dut4.rr_q), 64'h1);
        check_eq("s4_cnt", 64'(dut4.beat_cnt_q), 64'h0);

        // Reset during a ch3 beat (rr_ptr is 1 going in)
        b4.req_addr[3*32 +: 32] = 32'h4444;
        b4.req_addr[1*32 +: 32] = 32'h1111;
        b4.req_valid = 4'b1000;
        step();
        check_eq("s6_grant", 64'(grant4), 64'h8);
        step();
        check_eq("s6_cnt", 64'(dut4.beat_cnt_q), 64'h1);
        rst = 1'b1;
        step();
        check_eq("s6_rst_grant", 64'(grant4), 64'h0);
        check_eq("s6_rst_m_valid", 64'(b4.m_valid), 64'h0);
        check_eq("s6_rst_busy", 64'(busy4), 64'h0);
        check_eq("s6_rst_rr", 64'(dut4.rr_q), 64'h0);
        check_eq("s6_rst_cnt", 64'(dut4.beat_cnt_q), 64'h0);
        rst = 1'b0;
        b4.req_valid = 4'b0010;
        step();
        check_eq("s6_new_grant", 64'(grant4), 64'h2);
        check_eq("s6_new_m_addr", 64'(b4.m_addr), 64'h1111);

        // Three channels: move rr_ptr to 2, then ch0 and ch2 contend
        idle_inputs();
        do_reset();
        b3.req_addr[0*32 +: 32] = 32'h3000;
        b3.req_addr[2*32 +: 32] = 32'h3002;
        b3.m_ready = 1'b1;
        max_burst3 = 8'd1;
        b3.req_valid = 3'b010;
        step();
        b3.req_valid = 3'b000;
        step();
        check_eq("s5_rr_pre", 64'(dut3.rr_q), 64'h2);
        b3.req_valid = 3'b101;
        step();
        check_eq("s5_first", 64'(grant3), 64'h4);
        check_eq("s5_first_addr", 64'(b3.m_addr), 64'h3002);
        step();
        check_eq("s5_gap", 64'(grant3), 64'h0);
        check_eq("s5_rr_wrap", 64'(dut3.rr_q), 64'h0);
        step();
        check_eq("s5_second", 64'(grant3), 64'h1);
        check_eq("s5_second_addr", 64'(b3.m_addr), 64'h3000);
        b3.req_valid = 3'b000;
        step();
        check_eq("s5_rr_end", 64'(dut3.rr_q), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
